// File: rtl/aes_inv_cipher_if.sv
// Ciphertext/plaintext handshake and round-key lookup bundle for aes_inv_cipher.
// The master side is the block's environment; the slave side is the cipher core.
interface aes_inv_cipher_if;
    logic [127:0] data_in;
    logic         in_valid_in;
    logic         in_ready_out;
    logic [3:0]   rk_idx_out;
    logic [127:0] rk_in;
    logic [127:0] data_out;
    logic         out_valid_out;
    logic         out_ready_in;

    modport master (
        output data_in, in_valid_in, rk_in, out_ready_in,
        input  in_ready_out, rk_idx_out, data_out, out_valid_out
    );

    modport slave (
        input  data_in, in_valid_in, rk_in, out_ready_in,
        output in_ready_out, rk_idx_out, data_out, out_valid_out
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched by index.
// Optional AES_INV_CIPHER_STATS_EN adds blocks_done_out and busy_out.
module aes_inv_cipher #(
    parameter int unsigned NR = 10
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
`ifdef AES_INV_CIPHER_STATS_EN
    output logic [31:0]     blocks_done_out,
    output logic            busy_out,
`endif
    aes_inv_cipher_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]   st;
    logic [3:0]   rnd;
    logic [127:0] state_q;
    logic [127:0] sub_s;
    logic [127:0] ark_s;
    logic [127:0] imc_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); also maps 0 to 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int unsigned i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    // Multiples 0e/0b/0d/09 all derive from one x2/x4/x8 xtime chain per byte
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a  [4];
        logic [7:0]  me [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  m9 [4];
        logic [7:0]  m2;
        logic [7:0]  m4;
        logic [7:0]  m8;
        logic [31:0] o;
        o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            m2    = xtime(a[i]);
            m4    = xtime(m2);
            m8    = xtime(m4);
            me[i] = m8 ^ m4 ^ m2;
            mb[i] = m8 ^ m2 ^ a[i];
            md[i] = m8 ^ m4 ^ a[i];
            m9[i] = m8 ^ a[i];
        end
        for (int unsigned r = 0; r < 4; r++) begin
            o[31 - 8*r -: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    assign sub_s = inv_sub_bytes(inv_shift_rows(state_q));
    assign ark_s = sub_s ^ bus.rk_in;
    assign imc_s = inv_mix_columns(ark_s);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            st      <= IDLE;
            rnd     <= '0;
            state_q <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.in_valid_in) begin
                        state_q <= bus.data_in ^ bus.rk_in;
                        rnd     <= 4'(NR - 1);
                        st      <= ROUND;
                    end
                end
                ROUND: begin
                    if (rnd != 4'd0) begin
                        state_q <= imc_s;
                        rnd     <= rnd - 4'd1;
                    end else begin
                        state_q <= ark_s;
                        st      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_in) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_out  = (st == IDLE);
    assign bus.out_valid_out = (st == DONE);
    assign bus.rk_idx_out    = (st == ROUND) ? rnd : 4'(NR);
    assign bus.data_out      = state_q;

`ifdef AES_INV_CIPHER_STATS_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            blocks_done_out <= '0;
        end else if (st == DONE && bus.out_ready_in) begin
            blocks_done_out <= blocks_done_out + 32'd1;
        end
    end

    assign busy_out = (st != IDLE);
`endif

endmodule
